// File: rtl/qcl_lane_piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qcl_lane_piso_pkg
//  Description : Shared helpers for the QCL lane PISO. Holds the element
//                index mapping used to build the ordered view of the
//                parallel input array.
//  Revision    : 1.0  initial release
// ============================================================================
package qcl_lane_piso_pkg;

    // Maps ordered element j to its position in the packed input array.
    // With reversal selected, the array is read back to front so that
    // element 0 reaches the output head first.
    function automatic int unsigned qcl_src_index(
        input int unsigned j,
        input int unsigned els,
        input bit          rev
    );
        return rev ? (els - 1 - j) : j;
    endfunction

endpackage : qcl_lane_piso_pkg
`default_nettype wire

// File: rtl/qcl_lane_piso_lane.sv
`default_nettype none
// ============================================================================
//  Module      : qcl_piso_lane
//  Description : One transposed shift lane: an ELS_P-bit register with
//                synchronous active-low clear, parallel load and left shift
//                (zero fill). The MSB is the lane's serial output bit.
//  Ports       : clk_i      - clock, rising edge
//                reset_n_i  - synchronous active-low clear
//                load_i     - capture data_i (wins over shift_i)
//                shift_i    - shift left by one, fill bit 0 with 0
//                data_i     - parallel lane contents
//                data_o     - lane MSB, driven from the register
//  Revision    : 1.0  initial release
// ============================================================================
module qcl_piso_lane #(
    parameter int unsigned ELS_P = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [ELS_P-1:0] data_i,
    output logic             data_o
);

    logic [ELS_P-1:0] r_lane;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_lane <= '0;
        end else if (load_i) begin
            r_lane <= data_i;
        end else if (shift_i) begin
            r_lane <= {r_lane[ELS_P-2:0], 1'b0};
        end
    end

    assign data_o = r_lane[ELS_P-1];

endmodule : qcl_piso_lane
`default_nettype wire

// File: rtl/qcl_lane_piso.sv
`default_nettype none
// ============================================================================
//  Module      : qcl_lane_piso
//  Description : Parallel-in, serial-out shifter. Loads els_p elements of
//                width_p bits in one cycle and presents one element per
//                shift on data_o. Storage is transposed: one els_p-bit shift
//                lane per output bit. No handshake; the consumer pulses
//                shift_i per element taken.
//  Ports       : clk_i      - clock, rising edge
//                reset_n_i  - synchronous active-low reset, clears lanes
//                load_i     - capture data_i (priority over shift_i)
//                shift_i    - advance to the next element
//                data_i     - packed array, element j at [j*width_p +: width_p]
//                data_o     - current head element, registered
//  Revision    : 1.0  initial release
// ============================================================================
module qcl_lane_piso
    import qcl_lane_piso_pkg::*;
#(
    parameter int unsigned width_p    = 8,
    parameter int unsigned els_p      = 4,
    parameter int unsigned hi_to_lo_p = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       load_i,
    input  logic                       shift_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [width_p-1:0]         data_o
);

    // A single-element "shifter" has no serial order to speak of and would
    // also collapse the lane shift slice; refuse it outright.
    if (els_p <= 1) begin : g_bad_els
        $fatal(1, "qcl_lane_piso: els_p must be greater than 1");
    end

    // Ordered view of the input array (optionally reversed).
    logic [els_p-1:0][width_p-1:0] w_ordered;
    // Transposed view: lane i bit j = bit i of ordered element j.
    logic [width_p-1:0][els_p-1:0] w_lane_in;

    for (genvar j = 0; j < els_p; j++) begin : g_order
        localparam int unsigned c_SRC = qcl_src_index(j, els_p, hi_to_lo_p != 0);
        assign w_ordered[j] = data_i[c_SRC*width_p +: width_p];
    end

    for (genvar i = 0; i < width_p; i++) begin : g_lane
        for (genvar j = 0; j < els_p; j++) begin : g_bit
            assign w_lane_in[i][j] = w_ordered[j][i];
        end

        // Lane MSB holds ordered element els_p-1, so the head of the stream
        // is the last ordered element and shifting left walks down from it.
        qcl_piso_lane #(
            .ELS_P (els_p)
        ) u_lane (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .load_i    (load_i),
            .shift_i   (shift_i),
            .data_i    (w_lane_in[i]),
            .data_o    (data_o[i])
        );
    end

endmodule : qcl_lane_piso
`default_nettype wire

// File: tb/tb_qcl_lane_piso.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qcl_lane_piso
//  Description : Self-checking bench for qcl_lane_piso. Two 8x4 instances
//                (forward and reversed order) share one directed vector
//                table; a 1x8 instance is exercised by a hand-written
//                serial sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qcl_lane_piso;

    typedef struct {
        logic        rst_n;
        logic        load;
        logic        shift;
        logic [31:0] din;
        logic [7:0]  exp_fwd;
        logic [7:0]  exp_rev;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic        shift;
    logic [31:0] din;
    logic [7:0]  dout_fwd;
    logic [7:0]  dout_rev;

    logic        s_rst_n;
    logic        s_load;
    logic        s_shift;
    logic [7:0]  s_din;
    logic        s_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qcl_lane_piso #(.width_p(8), .els_p(4), .hi_to_lo_p(0)) u_dut_fwd (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .load_i    (load),
        .shift_i   (shift),
        .data_i    (din),
        .data_o    (dout_fwd)
    );

    qcl_lane_piso #(.width_p(8), .els_p(4), .hi_to_lo_p(1)) u_dut_rev (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .load_i    (load),
        .shift_i   (shift),
        .data_i    (din),
        .data_o    (dout_rev)
    );

    qcl_lane_piso #(.width_p(1), .els_p(8), .hi_to_lo_p(0)) u_dut_ser (
        .clk_i     (clk),
        .reset_n_i (s_rst_n),
        .load_i    (s_load),
        .shift_i   (s_shift),
        .data_i    (s_din),
        .data_o    (s_dout)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic l, input logic s,
                                input logic [31:0] d, input logic [7:0] ef,
                                input logic [7:0] er, input string n);
        vec_t v;
        v.rst_n = r; v.load = l; v.shift = s; v.din = d;
        v.exp_fwd = ef; v.exp_rev = er; v.name = n;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              rst load shift din           fwd    rev
        vecs.push_back(mk(0, 0, 0, 32'h0000_0000, 8'h00, 8'h00, "reset"));
        vecs.push_back(mk(1, 1, 0, 32'h4433_2211, 8'h44, 8'h11, "load"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h33, 8'h22, "shift1"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h22, 8'h33, "shift2"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h11, 8'h44, "shift3"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h00, 8'h00, "shift4_empty"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h00, 8'h00, "shift_past_empty"));
        vecs.push_back(mk(1, 1, 0, 32'h4433_2211, 8'h44, 8'h11, "reload"));
        vecs.push_back(mk(1, 0, 0, 32'hFFFF_FFFF, 8'h44, 8'h11, "hold1"));
        vecs.push_back(mk(1, 0, 0, 32'h1234_5678, 8'h44, 8'h11, "hold2"));
        vecs.push_back(mk(1, 0, 0, 32'h0000_0000, 8'h44, 8'h11, "hold3"));
        vecs.push_back(mk(1, 1, 1, 32'hDDCC_BBAA, 8'hDD, 8'hAA, "load_beats_shift"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'hCC, 8'hBB, "shift_after_ls"));
        vecs.push_back(mk(1, 1, 0, 32'h4433_2211, 8'h44, 8'h11, "load_pre_reset"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h33, 8'h22, "shift_pre_reset"));
        vecs.push_back(mk(0, 1, 0, 32'h4433_2211, 8'h00, 8'h00, "reset_beats_load"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h00, 8'h00, "shift_after_reset"));
        vecs.push_back(mk(1, 1, 0, 32'h4433_2211, 8'h44, 8'h11, "load_mid"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h33, 8'h22, "mid_shift1"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h22, 8'h33, "mid_shift2"));
        vecs.push_back(mk(1, 1, 0, 32'h0807_0605, 8'h08, 8'h05, "reload_mid"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h07, 8'h06, "reload_shift1"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h06, 8'h07, "reload_shift2"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h05, 8'h08, "reload_shift3"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 8'h00, 8'h00, "reload_empty"));

        rst_n = 1'b0; load = 1'b0; shift = 1'b0; din = '0;
        s_rst_n = 1'b0; s_load = 1'b0; s_shift = 1'b0; s_din = '0;

        foreach (vecs[k]) begin
            rst_n = vecs[k].rst_n;
            load  = vecs[k].load;
            shift = vecs[k].shift;
            din   = vecs[k].din;
            @(posedge clk);
            #1;
            check8({"fwd_", vecs[k].name}, dout_fwd, vecs[k].exp_fwd);
            check8({"rev_", vecs[k].name}, dout_rev, vecs[k].exp_rev);
        end

        // No combinational path: reload a fresh array, then wiggle every
        // input between edges; the head must not move until the next edge.
        rst_n = 1'b1; load = 1'b1; shift = 1'b0; din = 32'h4433_2211;
        @(posedge clk);
        #1;
        check8("fwd_comb_load", dout_fwd, 8'h44);
        load = 1'b1; shift = 1'b1; din = 32'h9988_7766; rst_n = 1'b0;
        #2;
        check8("fwd_no_comb_path", dout_fwd, 8'h44);
        check8("rev_no_comb_path", dout_rev, 8'h11);
        rst_n = 1'b1; load = 1'b0; shift = 1'b0;

        // Single-bit lane: serial stream of 8'b1011_0010, MSB first.
        @(negedge clk);
        s_rst_n = 1'b1; s_load = 1'b1; s_din = 8'b1011_0010;
        @(posedge clk);
        #1;
        check1("ser_bit0", s_dout, 1'b1);
        s_load = 1'b0; s_shift = 1'b1; s_din = 8'hFF;
        begin
            logic [7:0] pattern;
            pattern = 8'b1011_0010;
            for (int b = 1; b < 8; b++) begin
                @(posedge clk);
                #1;
                check1($sformatf("ser_bit%0d", b), s_dout, pattern[7-b]);
            end
        end
        @(posedge clk);
        #1;
        check1("ser_empty", s_dout, 1'b0);
        @(posedge clk);
        #1;
        check1("ser_past_empty", s_dout, 1'b0);
        s_shift = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_qcl_lane_piso
`default_nettype wire
